// File: rtl/msx_mem_arbiter.sv
// MSX memory arbiter: shares one single-port 256 KB RAM between Z80 memory cycles
// and the image loader, decodes the primary-slot register and stretches CPU reads with WAIT_n.
module msx_mem_arbiter #(
   parameter int unsigned RD_LAT    = 1,
   parameter logic [17:0] ROM_BASE  = 18'h00000,
   parameter logic [17:0] CART_BASE = 18'h08000,
   parameter logic [17:0] RAM_BASE  = 18'h10000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  slot_sel,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_dout,
   input  logic        cpu_mreq_n,
   input  logic        cpu_rd_n,
   input  logic        cpu_wr_n,
   input  logic        cpu_rfsh_n,
   output logic [7:0]  cpu_din,
   output logic        cpu_wait_n,
   input  logic        dl_wr,
   input  logic [17:0] dl_addr,
   input  logic [7:0]  dl_data,
   output logic        dl_ack,
   output logic [17:0] ram_addr,
   output logic [7:0]  ram_din,
   output logic        ram_we,
   input  logic [7:0]  ram_q
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] RD_WAIT = 2'd1;
   localparam logic [1:0] DL_WR   = 2'd2;
   localparam logic [1:0] LAT_M1  = 2'(RD_LAT - 1);

   logic [1:0]  state_r;
   logic [1:0]  cnt_r;
   logic        served_r;
   logic        dl_pend_r;
   logic        dl_wr_r;
   logic [1:0]  page_s;
   logic [1:0]  slot_s;
   logic [15:0] cart_off_s;
   logic        mapped_s;
   logic        writable_s;
   logic [17:0] map_addr_s;
   logic        is_read_s;
   logic        cpu_req_s;
   logic        completing_s;

   // Slot decode: page p uses slot_sel[2p+1:2p]; bases are aligned so offsets are ORed in
   always_comb begin
      page_s     = cpu_addr[15:14];
      cart_off_s = cpu_addr - 16'h4000;
      mapped_s   = 1'b0;
      writable_s = 1'b0;
      map_addr_s = 18'h00000;
      case (page_s)
         2'd0:    slot_s = slot_sel[1:0];
         2'd1:    slot_s = slot_sel[3:2];
         2'd2:    slot_s = slot_sel[5:4];
         default: slot_s = slot_sel[7:6];
      endcase
      case (slot_s)
         2'd0: begin
            if (page_s[1] == 1'b0) begin
               mapped_s   = 1'b1;
               map_addr_s = ROM_BASE | {3'b000, cpu_addr[14:0]};
            end else begin
               mapped_s   = 1'b0;
            end
         end
         2'd1: begin
            if (page_s == 2'd1 || page_s == 2'd2) begin
               mapped_s   = 1'b1;
               map_addr_s = CART_BASE | {3'b000, cart_off_s[14:0]};
            end else begin
               mapped_s   = 1'b0;
            end
         end
         2'd3: begin
            mapped_s   = 1'b1;
            writable_s = 1'b1;
            map_addr_s = RAM_BASE | {2'b00, cpu_addr};
         end
         default: mapped_s = 1'b0;
      endcase
   end

   // Request qualification; WAIT_n must react in the same cycle, so it stays combinational
   always_comb begin
      is_read_s = ~cpu_rd_n;
      cpu_req_s = ~reset & ~cpu_mreq_n & cpu_rfsh_n & (~cpu_rd_n | ~cpu_wr_n) & ~served_r;
      case (state_r)
         IDLE:    completing_s = ~(is_read_s & mapped_s);
         RD_WAIT: completing_s = (cnt_r == 2'd0);
         default: completing_s = 1'b0;
      endcase
   end

   assign cpu_wait_n = ~(cpu_req_s & ~completing_s);

   // Arbitration state machine and registered RAM / CPU / loader outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r   <= IDLE;
         cnt_r     <= 2'd0;
         served_r  <= 1'b0;
         dl_pend_r <= 1'b0;
         dl_wr_r   <= 1'b0;
         ram_addr  <= 18'h00000;
         ram_din   <= 8'h00;
         ram_we    <= 1'b0;
         cpu_din   <= 8'hFF;
         dl_ack    <= 1'b0;
      end else begin
         ram_we  <= 1'b0;
         dl_ack  <= 1'b0;
         dl_wr_r <= dl_wr;
         case (state_r)
            IDLE: begin
               if (cpu_req_s) begin
                  if (is_read_s) begin
                     if (mapped_s) begin
                        ram_addr <= map_addr_s;
                        cnt_r    <= LAT_M1;
                        state_r  <= RD_WAIT;
                     end else begin
                        cpu_din  <= 8'hFF;
                        served_r <= 1'b1;
                     end
                  end else begin
                     if (writable_s) begin
                        ram_addr <= map_addr_s;
                        ram_din  <= cpu_dout;
                        ram_we   <= 1'b1;
                     end else begin
                        ram_we   <= 1'b0;
                     end
                     served_r <= 1'b1;
                  end
               end else if (dl_pend_r) begin
                  ram_addr <= dl_addr;
                  ram_din  <= dl_data;
                  ram_we   <= 1'b1;
                  state_r  <= DL_WR;
               end else begin
                  state_r  <= IDLE;
               end
            end
            RD_WAIT: begin
               if (cnt_r == 2'd0) begin
                  cpu_din  <= ram_q;
                  served_r <= 1'b1;
                  state_r  <= IDLE;
               end else begin
                  cnt_r    <= cnt_r - 2'd1;
               end
            end
            DL_WR: begin
               dl_ack  <= 1'b1;
               state_r <= IDLE;
            end
            default: state_r <= IDLE;
         endcase
         // End of the CPU cycle re-arms the next request; a late read completion cannot block it
         if (cpu_mreq_n) begin
            served_r <= 1'b0;
         end
         if (dl_wr && !dl_wr_r) begin
            dl_pend_r <= 1'b1;
         end else if (state_r == DL_WR) begin
            dl_pend_r <= 1'b0;
         end else begin
            dl_pend_r <= dl_pend_r;
         end
      end
   end

endmodule
